clkgate_seq: RTL
================

// Module: clkgate_seq
// PURPOSE
//  Sequencer for the gate enables of NUM_DOM gated clock buffers (clkbuf + ICG cells) fed from one root clock.
//  Takes per-domain level requests and applies enable changes one domain at a time, with a guaranteed settle gap between changes.
//  The gap limits supply di/dt on clock-tree turn-on and turn-off.
//  Sits beside the clock-buffer/ICG cells; the gated clock outputs feed dff clkbuf_sink pins downstream.
// PARAMETERS
//  NUM_DOM  4  number of gated clock domains (2..16)
//  STAGGER  3  settle cycles after each enable change (>=1)
// PORTS
//  clk      in   1        root clock; one clock only
//  rst_n    in   1        asynchronous active-low reset
//  req      in   NUM_DOM  desired gate state per domain (level, synchronous to clk)
//  freeze   in   1        high: no new change is started; an in-progress settle still completes
//  gate_en  out  NUM_DOM  registered enable to each clock gate cell
//  ack      out  NUM_DOM  settled gate state; equals gate_en[i] once its settle has finished
//  busy     out  1        high while in SETTLE
// BEHAVIOUR
//  Reset (async assert, sync release): gate_en=0, ack=0, busy=0, state=IDLE, ptr=0, cnt=0.
//  Mismatch set: pend[i] = req[i] ^ gate_en[i]. Off-class: pend & gate_en. On-class: pend & ~gate_en.
//  FSM states: IDLE, SETTLE.
//  IDLE, when freeze=0 and pend!=0:
//   - Choose sel from the off-class if it is non-empty, otherwise from the on-class.
//   - Within the chosen class, pick round-robin, searching from ptr upward with wrap at NUM_DOM-1 -> 0.
//   - At the edge: gate_en[sel] toggles, ptr <= (sel+1) mod NUM_DOM, cnt <= STAGGER-1, state -> SETTLE, busy <= 1.
//  IDLE, otherwise: hold everything.
//  SETTLE:
//   - cnt decrements each cycle.
//   - At cnt==0 edge: ack[sel] <= gate_en[sel], state -> IDLE, busy <= 0.
//  Latency:
//   - Mismatch visible in IDLE -> gate_en toggles at the next edge (1 cycle).
//   - ack follows STAGGER cycles after the toggle.
//   - Minimum spacing between any two gate_en toggles: STAGGER+1 cycles.
//  Only one gate_en bit changes per edge, ever; ack bits change only for sel, one at a time.
//  req changes during SETTLE: ignored until IDLE; a reverted req causes a toggle back afterwards (no cancel).
//  freeze asserted during SETTLE: settle completes and ack updates; FSM then holds in IDLE until freeze=0.
//  Simultaneous off and on mismatches: all off-class served before any on-class, independent of ptr.
//  Reset mid-SETTLE: gates drop to 0 immediately (async); no sequencing on reset.
//  sel and cnt are internal registers; cnt width is $clog2(STAGGER+1), minimum 1.
// STRUCTURE
//  Package clkgate_seq_pkg: state enum {IDLE, SETTLE}; function for cnt width.
//  Sub-module rr_pick #(N): mask[N], ptr -> gnt_idx, gnt_vld (combinational round-robin search).
//   - Instantiated twice (off-class, on-class); class priority mux lives in clkgate_seq.
//  Remainder: FSM, counter, gate_en/ack/ptr registers.
// TESTING (NUM_DOM=4, STAGGER=3)
//  1. Reset, then req=4'b0001: gate_en=0001 at edge 1, ack=0001 at edge 4, busy high on edges 1..3.
//  2. req=4'b1111 from all-off: bits toggle in order 0,1,2,3 at edges 1,5,9,13.
//     ack reaches 1111 at edge 16; never two gate_en bits change on one edge.
//  3. gate_en=1111, ptr=2, then req=4'b0000: turn-off order is 2,3,0,1, 4 cycles apart.
//  4. gate_en=0011, req=4'b1100 in one cycle: bits 0 and 1 turn off first, then bits 2 and 3 turn on.
//  5. req[0] set then cleared during SETTLE: gate_en[0] goes 1 -> 0, 4 cycles apart; ack[0] pulses 1 then 0.
//  6. freeze=1 with pend!=0: no toggles. Release freeze: toggle on next edge.
//     Then drop rst_n mid-SETTLE: gate_en/ack/busy go to 0 without a clock edge.

Source files
------------

// File: rtl/clkgate_seq_pkg.sv
// Shared types and sizing helpers for the clock-gate enable sequencer.
// Imported by the sequencer top and its round-robin picker.
package clkgate_seq_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    SETTLE = 1'b1
  } state_t;

  // Settle counter must hold STAGGER-1; never narrower than one bit.
  function automatic int cnt_w(input int stagger);
    int w;
    w = $clog2(stagger + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/clkgate_seq_rr_pick.sv
// Combinational round-robin search over a request mask.
// Scans upward from ptr, wrapping N-1 -> 0; first set bit wins.
module rr_pick
  import clkgate_seq_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]         mask,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 gnt_vld
);

  localparam int IW = $clog2(N);

  int j;

  // Walk N positions starting at ptr; latch the first hit.
  always_comb begin
    gnt_idx = '0;
    gnt_vld = 1'b0;
    j       = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!gnt_vld && mask[j]) begin
        gnt_vld = 1'b1;
        gnt_idx = IW'(j);
      end
    end
  end

endmodule

// File: rtl/clkgate_seq.sv
// Sequences ICG enables one domain at a time with a fixed settle gap.
// Turn-offs drain before turn-ons to bound clock-tree di/dt.
module clkgate_seq
  import clkgate_seq_pkg::*;
#(
  parameter int NUM_DOM = 4,
  parameter int STAGGER = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_DOM-1:0] req,
  input  logic               freeze,
  output logic [NUM_DOM-1:0] gate_en,
  output logic [NUM_DOM-1:0] ack,
  output logic               busy
);

  localparam int IW = $clog2(NUM_DOM);
  localparam int CW = cnt_w(STAGGER);
  localparam logic [CW-1:0] CNT_LOAD = CW'(STAGGER - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DOM - 1);

  state_t state_q, state_d;

  logic [IW-1:0] sel_q, sel_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [NUM_DOM-1:0] gate_d;
  logic [NUM_DOM-1:0] ack_d;
  logic               busy_d;

  logic [NUM_DOM-1:0] pend;
  logic [NUM_DOM-1:0] off_mask;
  logic [NUM_DOM-1:0] on_mask;

  logic [IW-1:0] off_idx, on_idx;
  logic          off_vld, on_vld;
  logic [IW-1:0] pick_idx;
  logic          start;

  assign pend     = req ^ gate_en;
  assign off_mask = pend & gate_en;
  assign on_mask  = pend & ~gate_en;

  rr_pick #(
    .N (NUM_DOM)
  ) u_off_pick (
    .mask    (off_mask),
    .ptr     (ptr_q),
    .gnt_idx (off_idx),
    .gnt_vld (off_vld)
  );

  rr_pick #(
    .N (NUM_DOM)
  ) u_on_pick (
    .mask    (on_mask),
    .ptr     (ptr_q),
    .gnt_idx (on_idx),
    .gnt_vld (on_vld)
  );

  // Off-class always outranks on-class, regardless of ptr.
  always_comb begin
    pick_idx = on_idx;
    unique case (1'b1)
      off_vld: pick_idx = off_idx;
      default: pick_idx = on_idx;
    endcase
  end

  assign start = (state_q == IDLE) && !freeze
              && (off_vld || on_vld);

  // Next-state and next-register values for the sequencer.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gate_d  = gate_en;
    ack_d   = ack;
    busy_d  = busy;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          gate_d[pick_idx] = ~gate_en[pick_idx];
          sel_d   = pick_idx;
          ptr_d   = (pick_idx == LAST_IDX)
                  ? '0 : pick_idx + IW'(1);
          cnt_d   = CNT_LOAD;
          state_d = SETTLE;
          busy_d  = 1'b1;
        end
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          ack_d[sel_q] = gate_en[sel_q];
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset drops every gate at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      gate_en <= '0;
      ack     <= '0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gate_en <= gate_d;
      ack     <= ack_d;
      busy    <= busy_d;
    end
  end

endmodule
